// File: rtl/pb_gpio_bank.sv
// Multi-port GPIO bank for the Picoblaze I/O bus: per-port data latch, direction,
// synchronised readback and maskable sticky edge interrupts.
module pb_gpio_bank #(
    parameter logic [7:0]  BASE_ADDR      = 8'h00,
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned IRQ_BOTH_EDGES = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             port_id,
    input  logic [7:0]             data_in,
    input  logic                   write_strobe,
    input  logic                   read_strobe,
    output logic [7:0]             data_out,
    output logic                   interrupt,
    inout  wire  [NUM_PORTS*8-1:0] gpio
);
    localparam int unsigned W     = NUM_PORTS * 8;
    localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 1);
    localparam logic [8:0]  WIN   = 9'(4 * NUM_PORTS);

    typedef enum logic {
        DISARMED,
        ARMED
    } arm_state_t;

    arm_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NUM_PORTS-1:0][7:0] data_q, dir_q, mask_q, stat_q, stat_d;
    logic [NUM_PORTS-1:0][7:0] clr, pin_sync;
    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0] dly_q, pin_flat, dir_flat, data_flat;
    logic [W-1:0] rise, fall, edge_set;

    logic [7:0]           offset;
    logic [5:0]           sel_port;
    logic [1:0]           sel_reg;
    logic                 hit;
    logic [NUM_PORTS-1:0] port_sel;
    logic [7:0]           rd_data;
    logic                 unused_rd;

    assign unused_rd = read_strobe;

    assign offset   = port_id - BASE_ADDR;
    assign hit      = (port_id >= BASE_ADDR) && ({1'b0, offset} < WIN);
    assign sel_port = offset[7:2];
    assign sel_reg  = offset[1:0];

    always_comb begin
        port_sel = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            port_sel[p] = hit && (sel_port == 6'(p));
        end
    end

    assign dir_flat  = dir_q;
    assign data_flat = data_q;

    for (genvar i = 0; i < W; i++) begin : g_pin
        assign gpio[i] = dir_flat[i] ? data_flat[i] : 1'bz;
    end

    assign pin_sync = sync_q[SYNC_STAGES-1];
    assign pin_flat = sync_q[SYNC_STAGES-1];

    // Arming counter: suppress edges until the synchroniser and delay flop hold real pin state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            DISARMED: begin
                if (cnt_q == CNT_W'(SYNC_STAGES)) begin
                    state_d = ARMED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ARMED: state_d = ARMED;
        endcase
    end

    assign rise     = pin_flat & ~dly_q;
    assign fall     = ~pin_flat & dly_q;
    assign edge_set = (state_q == ARMED)
                    ? ((rise | ((IRQ_BOTH_EDGES != 0) ? fall : '0)) & ~dir_flat)
                    : '0;

    // A new edge overrides a same-cycle write-1-to-clear.
    always_comb begin
        clr = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (write_strobe && port_sel[p] && (sel_reg == 2'd3)) begin
                clr[p] = data_in;
            end
        end
        stat_d = (stat_q & ~clr) | edge_set;
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (port_sel[p]) begin
                case (sel_reg)
                    2'd0:    rd_data = pin_sync[p];
                    2'd1:    rd_data = dir_q[p];
                    2'd2:    rd_data = mask_q[p];
                    default: rd_data = stat_q[p];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= DISARMED;
            cnt_q     <= '0;
            data_q    <= '0;
            dir_q     <= '0;
            mask_q    <= '0;
            stat_q    <= '0;
            sync_q    <= '0;
            dly_q     <= '0;
            data_out  <= '0;
            interrupt <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stat_q    <= stat_d;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], gpio};
            dly_q     <= pin_flat;
            data_out  <= rd_data;
            interrupt <= |(stat_q & mask_q);
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (write_strobe && port_sel[p]) begin
                    case (sel_reg)
                        2'd0:    data_q[p] <= data_in;
                        2'd1:    dir_q[p]  <= data_in;
                        2'd2:    mask_q[p] <= data_in;
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule
